// File: rtl/bitty_uart_tx.sv
// Bus-mapped 8N1 UART transmitter with a small TX FIFO.
// Latency: ack 1 cycle after request; tx_o falls 2 cycles after the ack of the first byte.
// Backpressure: none on the bus; TXDATA writes into a full FIFO are dropped and flag overflow.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   mem_ce_i/mem_we_i      single-cycle bus request / write strobe
//   mem_addr_i[3:2]        register select: 0 TXDATA, 1 STATUS, 2/3 unmapped
//   mem_data_i/mem_data_o  write data / read data (0 outside the ack cycle)
//   mem_ack_o              one-cycle response, one per request
//   tx_o                   serial line, idle high, driven from a flop
module bitty_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        tx_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  // Transmitter state
  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  // Bus response
  logic          r_ack;
  logic [31:0]   r_rdata;

  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_baud_end;
  logic          w_pop;
  logic          w_wr_txdata;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_rd_status;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_baud_end = (r_baud == BW'(CLK_DIV - 1));

  // The FSM pops when idle, or at the last cycle of a stop bit so the next
  // start bit follows without a gap.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

  assign w_wr_txdata = mem_ce_i && mem_we_i && (mem_addr_i[3:2] == 2'd0);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign w_push      = w_wr_txdata && (!w_full || w_pop);
  assign w_ovf_set   = w_wr_txdata && w_full && !w_pop;
  assign w_ovf_clr   = mem_ce_i && mem_we_i && (mem_addr_i[3:2] == 2'd1) && mem_data_i[3];
  assign w_rd_status = mem_ce_i && !mem_we_i && (mem_addr_i[3:2] == 2'd1);

  assign w_status = {28'd0, r_ovf, w_busy, w_empty, w_full};

  // Address/data bits outside the decoded fields are intentionally ignored.
  assign w_unused = ^{mem_addr_i[31:4], mem_addr_i[1:0], mem_data_i[31:8]};

  // FIFO storage: no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= mem_data_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over clear.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Transmit FSM. tx_o is registered from the current state, so the line
  // lags the state by one cycle; every bit still lasts exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase

      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
        end
      endcase
    end
  end

  // Every request is acked next cycle; only STATUS reads return data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= mem_ce_i;
      r_rdata <= w_rd_status ? w_status : 32'd0;
    end
  end

  assign mem_ack_o  = r_ack;
  assign mem_data_o = r_rdata;
  assign tx_o       = r_tx;

endmodule

// File: tb/tb_bitty_uart_tx.sv
module tb_bitty_uart_tx;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        tx_o;

  bitty_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .mem_ack_o  (mem_ack_o),
    .tx_o       (tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          rst_count = 0;
  logic [31:0] exp_ack_q[$];
  logic [7:0]  exp_byte_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one bus request at the current negedge; expected read data goes to the scoreboard.
  task automatic bus_op(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd);
    mem_ce_i   = 1'b1;
    mem_we_i   = we;
    mem_addr_i = addr;
    mem_data_i = data;
    exp_ack_q.push_back(exp_rd);
    @(negedge clk);
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'd0;
    mem_data_i = 32'd0;
  endtask

  // Bus response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_ack_o === 1'b1) begin
          if (exp_ack_q.size() == 0) begin
            chk("spurious_ack", 32'd1, 32'd0);
          end else begin
            chk("ack_rdata", mem_data_o, exp_ack_q.pop_front());
          end
        end else begin
          chk("ack_level", {31'd0, mem_ack_o}, 32'd0);
          chk("rdata_idle_zero", mem_data_o, 32'd0);
        end
      end
    end
  end

  // Serial line monitor: decodes frames at bit centres.
  logic [7:0] sm_byte;
  logic       sm_start;
  logic       sm_stop;
  int         sm_rc;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx_o === 1'b0) begin
        sm_rc = rst_count;
        repeat (DIV / 2) @(negedge clk);
        sm_start = tx_o;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          sm_byte[k] = tx_o;
        end
        repeat (DIV) @(negedge clk);
        sm_stop = tx_o;
        if (sm_rc == rst_count) begin
          chk("start_bit", {31'd0, sm_start}, 32'd0);
          chk("stop_bit", {31'd0, sm_stop}, 32'd1);
          if (exp_byte_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, sm_byte}, 32'hFFFF_FFFF);
          end else begin
            chk("frame_byte", {24'd0, sm_byte}, {24'd0, exp_byte_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [9:0] pat55;
  bit         saw_low;

  initial begin
    rst        = 1'b1;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'd0;
    mem_data_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_tx", {31'd0, tx_o}, 32'd1);
    chk("reset_ack", {31'd0, mem_ack_o}, 32'd0);
    chk("reset_rdata", mem_data_o, 32'd0);
    mon_en = 1'b1;
    bus_op(1'b0, 32'h4, 32'd0, 32'h2);

    // Single frame 0x55: start, LSB-first data, stop.
    pat55 = 10'b1010101010;
    exp_byte_q.push_back(8'h55);
    bus_op(1'b1, 32'h0, 32'hABCD_EF55, 32'd0);
    chk("lat_ack_cycle", {31'd0, tx_o}, 32'd1);
    @(negedge clk);
    chk("lat_plus1", {31'd0, tx_o}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 10 * DIV; i++) begin
      chk("frame55_bit", {31'd0, tx_o}, {31'd0, pat55[i / DIV]});
      @(negedge clk);
    end
    chk("idle_after_frame", {31'd0, tx_o}, 32'd1);
    bus_op(1'b0, 32'h4, 32'd0, 32'h2);

    // Unmapped and write-only reads return 0; unmapped write ignored.
    bus_op(1'b0, 32'h8, 32'd0, 32'd0);
    bus_op(1'b0, 32'h0, 32'd0, 32'd0);
    bus_op(1'b1, 32'hC, 32'hFF, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'h2);
    repeat (5) @(negedge clk);

    // Back-to-back frames.
    exp_byte_q.push_back(8'hA5);
    exp_byte_q.push_back(8'h3C);
    bus_op(1'b1, 32'h0, 32'hA5, 32'd0);
    bus_op(1'b1, 32'h0, 32'h3C, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'h4);
    repeat (39) @(negedge clk);
    chk("b2b_stop_bit", {31'd0, tx_o}, 32'd1);
    @(negedge clk);
    chk("b2b_next_start", {31'd0, tx_o}, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'h6);
    repeat (50) @(negedge clk);
    bus_op(1'b0, 32'h4, 32'd0, 32'h2);
    repeat (5) @(negedge clk);

    // Overflow: 1 popped + 4 queued, 6th dropped.
    exp_byte_q.push_back(8'h11);
    exp_byte_q.push_back(8'h22);
    exp_byte_q.push_back(8'h33);
    exp_byte_q.push_back(8'h44);
    exp_byte_q.push_back(8'h66);
    bus_op(1'b1, 32'h0, 32'h11, 32'd0);
    bus_op(1'b1, 32'h0, 32'h22, 32'd0);
    bus_op(1'b1, 32'h0, 32'h33, 32'd0);
    bus_op(1'b1, 32'h0, 32'h44, 32'd0);
    bus_op(1'b1, 32'h0, 32'h66, 32'd0);
    bus_op(1'b1, 32'h0, 32'h77, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'hD);
    bus_op(1'b1, 32'h4, 32'h8, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'h5);

    // Full FIFO, write lands on the cycle the FSM pops at the end of the stop bit.
    repeat (32) @(negedge clk);
    exp_byte_q.push_back(8'h88);
    bus_op(1'b1, 32'h0, 32'h88, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'h5);

    // Reset mid-DATA of the 4th frame with two bytes still queued; a write during reset is ignored.
    repeat (92) @(negedge clk);
    rst_count++;
    rst        = 1'b1;
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b1;
    mem_addr_i = 32'h0;
    mem_data_i = 32'h99;
    @(negedge clk);
    rst        = 1'b0;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_data_i = 32'd0;
    chk("rst_tx_high", {31'd0, tx_o}, 32'd1);
    exp_byte_q.delete();
    bus_op(1'b0, 32'h4, 32'd0, 32'h2);
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx_o !== 1'b1) saw_low = 1'b1;
    end
    chk("no_frames_after_rst", {31'd0, saw_low}, 32'd0);
    bus_op(1'b0, 32'h4, 32'd0, 32'h2);

    repeat (3) @(negedge clk);
    chk("acks_outstanding", exp_ack_q.size(), 32'd0);
    chk("frames_outstanding", exp_byte_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitty_uart_tx.md
BITTY_UART_TX -- requirements
Module: bitty_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 434, means clk cycles per serial bit (50 MHz / 115200); legal range is 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, means TX FIFO entries; it SHALL be a power of two, 2..64.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_ce_i  input  1  bus request from the core data port, single-cycle.
REQ-006 mem_we_i  input  1  1 = write, 0 = read; qualified by mem_ce_i.
REQ-007 mem_addr_i  input  32  byte address; only bits [3:2] are decoded.
REQ-008 mem_data_i  input  32  write data.
REQ-009 mem_data_o  output  32  read data; valid only while mem_ack_o=1, else 0.
REQ-010 mem_ack_o  output  1  one-cycle response pulse.
REQ-011 tx_o  output  1  serial line, 8N1, idle high.

Function
REQ-012 Every request (mem_ce_i=1) SHALL produce exactly one mem_ack_o pulse in the following cycle; a back-to-back request each cycle SHALL get an ack each cycle.
REQ-013 Register map by addr[3:2]: 0 = TXDATA (write-only, reads 0); 1 = STATUS (read/write); 2, 3 = unmapped (reads 0, writes ignored, still acked).
REQ-014 Write to TXDATA with the FIFO not full SHALL push mem_data_i[7:0]; bits [31:8] are ignored.
REQ-015 Write to TXDATA with the FIFO full SHALL drop the byte and set the sticky overflow flag.
REQ-016 STATUS read: bit0 = full, bit1 = empty, bit2 = busy (FSM not IDLE), bit3 = overflow, bits[31:4] = 0; values are sampled in the request cycle.
REQ-017 STATUS write with mem_data_i[3]=1 SHALL clear overflow; other bits are ignored. If an overflowing push and the clear occur in the same cycle, set wins (cannot occur on a single-port bus).
REQ-018 FIFO: circular, log2(FIFO_DEPTH)+1-bit count. Full is count==FIFO_DEPTH; empty is count==0. Pointers wrap modulo FIFO_DEPTH.
REQ-019 Simultaneous push and pop SHALL leave count unchanged. When full, a simultaneous pop and push SHALL be accepted (pop evaluated first), with no overflow.
REQ-020 FSM states: IDLE, START, DATA, STOP; a bit counter of 0..7 and a baud counter of 0..CLK_DIV-1.
REQ-021 IDLE: tx_o=1. If the FIFO is not empty, pop into the shift register and go to START in the next cycle.
REQ-022 START: tx_o=0 for CLK_DIV cycles, then go to DATA.
REQ-023 DATA: tx_o = shift[0], LSB first, CLK_DIV cycles per bit, 8 bits, then go to STOP.
REQ-024 STOP: tx_o=1 for CLK_DIV cycles. At the end, if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
REQ-025 Frame length is exactly 10*CLK_DIV cycles. Latency from the ack cycle of the first TXDATA write (FIFO empty, IDLE) to the tx_o falling edge is 2 cycles.
REQ-026 tx_o SHALL be driven from a flop (glitch-free).

Reset
REQ-027 On rst=1 at a clk edge: FSM=IDLE, tx_o=1, FIFO emptied (pointers and count = 0), overflow=0, mem_ack_o=0, mem_data_o=0, counters=0.
REQ-028 Reset mid-frame SHALL abort the frame: tx_o=1 on the next cycle, and queued bytes are discarded.
REQ-029 A request during rst=1 SHALL be ignored, with no ack after reset.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-030 Write 0x55 to TXDATA -> ack next cycle; tx_o falls 2 cycles after the ack; it then shows 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop), each held 4 cycles; 40 cycles total, then idle high.
REQ-031 Write 0xA5, then 0x3C on consecutive cycles -> two frames with the second start bit immediately after the first stop bit; STATUS.busy=1 throughout, empty=1 after the second pop.
REQ-032 Write 6 bytes while the first frame is in flight -> 1 popped plus 4 queued accepted, 6th dropped; STATUS reads full=1, overflow=1; write STATUS 0x8 -> overflow=0.
REQ-033 Read unmapped address 0x8 and read TXDATA -> ack next cycle with mem_data_o=0; no FIFO change.
REQ-034 Assert rst for 1 cycle mid-DATA of a frame with 2 bytes queued -> tx_o=1 the next cycle, STATUS=0x2, and no further frames.
REQ-035 Full FIFO, write on the cycle the FSM pops -> byte accepted, overflow stays 0, count stays 4.
